cla_seq_adder_ctrl: RTL and testbench
=====================================

Name: cla_seq_adder_ctrl

Overview:
- Sequencing controller that adds WIDTH-bit operands over several cycles by reusing one 4-bit carry-lookahead slice.
- The slice is a single internal cla_4bit instance, inputs a, b, cin and output s[4:0].
- The block processes one nibble per cycle, least significant first, and carries between slices through a carry register.
- It has valid/ready handshakes on the operand side and the result side, and supports add and subtract.

Parameters:
- WIDTH, 16: operand and sum width. Must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4: derived slice count. Not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry-in. Used only when sub=0.
- sub  in  1  1 = A - B
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB slice. For subtract, 1 means no borrow.
- ovf  out  1  signed overflow
- busy  out  1  high in RUN

Behaviour:
- Reset: sampled only at the rising clk edge while rst_n=0, and has priority over everything else.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
  - Slice counter, carry register and operand registers are cleared.
- Reset mid-operation: applying reset in RUN or DONE aborts the operation and discards the partial or held result. No out_valid pulse is produced.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept: a transfer occurs when in_valid & in_ready at an edge. At that edge:
  - Register a_r = a and b_r = (sub ? ~b : b).
  - Set the carry register to (sub ? 1 : cin) and the slice index k to 0.
  - Go to RUN.
  - Inputs sampled while in_ready=0 are ignored. Operand changes after accept have no effect.
- RUN: each cycle the slice computes a_r[4k+3:4k] + b_r[4k+3:4k] + carry. At the edge:
  - Write s[3:0] into sum[4k+3:4k] and s[4] into the carry register.
  - Increment k.
  - When k==NSLICE-1: set cout = s[4] and set ovf, then go to DONE.
- Latency: out_valid rises exactly NSLICE edges after the accept edge (4 for WIDTH=16). busy=1 for exactly NSLICE cycles.
- sum bits are updated only during RUN. The upper nibbles hold 0, or the previous result, until they are written. Consumers use sum only while out_valid=1.
- ovf = (a_r[MSB]==b_r[MSB]) & (final sum[MSB] != a_r[MSB]), where b_r is the post-inversion value.
- DONE: out_valid=1, and sum/cout/ovf are held stable while out_ready=0, for as many cycles as needed. On an edge with out_ready=1:
  - If in_valid=1: new operands are accepted at the same edge, out_valid falls, and the state goes to RUN.
  - Else: out_valid falls and the state goes to IDLE.
- Arithmetic: modulo 2^WIDTH. cout and ovf are the only extended information.
- WIDTH=4: RUN lasts a single cycle.

Test Plan (WIDTH=16):
- Add with carry-out: accept a=0xFFFF, b=0x0001, cin=0, sub=0 -> out_valid exactly 4 edges after accept; sum=0x0000, cout=1, ovf=0; busy high 4 cycles.
- Signed overflow and cin: a=0x7FFF, b=0x0000, cin=1, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure and ignore: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout, ovf stable and in_ready=0. Toggle in_valid with new operands during RUN -> no effect on the result.
- Back-to-back: in DONE with out_ready=1 and in_valid=1 (a=0x0001, b=0x0002) -> the old result is consumed and the new operands are accepted at the same edge; next out_valid 4 edges later with sum=0x0003.
- Reset mid-RUN: assert rst_n=0 for one cycle at k=2 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0, and no result is emitted. A following add of 0x0010+0x0020 -> 0x0030.

Source files
------------

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl
// Sequential WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead
// slice. It processes one nibble per cycle, least significant nibble first, and
// passes the carry between nibbles through a carry register.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   operand request
//   in_ready   block can accept operands
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in, ignored when sub=1
//   sub        1 = a - b
//   out_valid  result available
//   out_ready  consumer takes the result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB slice (for subtract, 1 = no borrow)
//   ovf        signed overflow
//   busy       high while nibbles are being processed

// 4-bit carry-lookahead slice: s[3:0] is the sum nibble, s[4] is the carry out.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] s
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = {c[4], p ^ c[3:0]};
  end
endmodule

module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  // Keep the slice index at least one bit wide so WIDTH=4 still elaborates.
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic [KW-1:0]    k;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [4:0]       slice_s;
  logic             last;
  logic             accept;

  // Select the nibble pair addressed by k with constant part-selects.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (k == KW'(i)) begin
        slice_a = a_r[4*i +: 4];
        slice_b = b_r[4*i +: 4];
      end
    end
  end

  cla_4bit u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry),
    .s   (slice_s)
  );

  assign last = (k == KW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // In DONE, a consuming edge may also accept the next operands.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nx = in_valid ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Subtraction is a + ~b + 1, so b is inverted and the carry preset on accept.
  // Upper sum nibbles are not cleared on accept; they keep the previous result
  // until RUN overwrites them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      k      <= '0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      k     <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NSLICE; i++) begin
        if (k == KW'(i)) sum_r[4*i +: 4] <= slice_s[3:0];
      end
      carry <= slice_s[4];
      k     <= k + KW'(1);
      if (last) begin
        cout_r <= slice_s[4];
        ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (slice_s[3] != a_r[WIDTH-1]);
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb_cla_seq_adder_ctrl
// Self-checking bench for cla_seq_adder_ctrl (WIDTH=16). The reference model
// computes results with plain integer arithmetic. Directed cases cover the
// listed corner cases, followed by randomized operations with random
// backpressure and back-to-back transfers.
module tb_cla_seq_adder_ctrl;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;
  logic             exp_ovf;

  cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: unsigned result for sum/cout, signed range for ovf.
  task automatic model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic ci, input logic sb);
    int ua;
    int ub;
    int ur;
    int sa;
    int sbv;
    int sr;
    ua  = int'(av);
    ub  = int'(bv);
    sa  = int'($signed(av));
    sbv = int'($signed(bv));
    if (sb) begin
      ur       = ua - ub;
      exp_cout = (ua >= ub);
      sr       = sa - sbv;
    end else begin
      ur       = ua + ub + int'(ci);
      exp_cout = (ur > 65535);
      sr       = sa + sbv + int'(ci);
    end
    exp_sum = WIDTH'(ur);
    exp_ovf = (sr > 32767) || (sr < -32768);
  endtask

  // Call between edges. Presents operands, lets the next edge accept them,
  // then scrambles the operand inputs to show later changes are ignored.
  task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic ci, input logic sb);
    a        = av;
    b        = bv;
    cin      = ci;
    sub      = sb;
    in_valid = 1'b1;
    #1;
    check_output("in_ready_accept", in_ready, 1);
    model(av, bv, ci, sb);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = WIDTH'($urandom);
    b         = WIDTH'($urandom);
    cin       = 1'($urandom);
    sub       = 1'($urandom);
    check_output("out_valid_after_accept", out_valid, 0);
    check_output("busy_after_accept", busy, 1);
  endtask

  // Waits for the result with a cycle bound, toggling in_valid with junk
  // operands during RUN, then checks and holds the result for 'hold' cycles.
  task automatic wait_result(input int hold);
    int edges;
    int busycnt;
    edges   = 0;
    busycnt = 0;
    @(negedge clk);
    while (!out_valid && edges < 20) begin
      if (busy) begin
        busycnt++;
        check_output("in_ready_run", in_ready, 0);
      end
      in_valid = 1'($urandom);
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      @(negedge clk);
      edges++;
    end
    in_valid = 1'b0;
    check_output("latency", edges, 4);
    check_output("busy_cycles", busycnt, 4);
    check_output("out_valid", out_valid, 1);
    check_output("busy_done", busy, 0);
    check_output("sum", sum, exp_sum);
    check_output("cout", cout, exp_cout);
    check_output("ovf", ovf, exp_ovf);
    check_output("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      a        = WIDTH'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      check_output("hold_out_valid", out_valid, 1);
      check_output("hold_sum", sum, exp_sum);
      check_output("hold_cout", cout, exp_cout);
      check_output("hold_ovf", ovf, exp_ovf);
      check_output("hold_in_ready", in_ready, 0);
    end
  endtask

  // Consume the held result without offering new operands.
  task automatic consume();
    out_ready = 1'b1;
    #1;
    check_output("in_ready_consume", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output("out_valid_consumed", out_valid, 0);
    check_output("in_ready_idle", in_ready, 1);
    check_output("busy_idle", busy, 0);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic ci, input logic sb, input int hold);
    apply_stimulus(av, bv, ci, sb);
    wait_result(hold);
    consume();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_sum", sum, 0);
    check_output("rst_cout", cout, 0);
    check_output("rst_ovf", ovf, 0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 2);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);

    // Long backpressure, then back-to-back transfer in the consuming edge.
    apply_stimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_result(5);
    out_ready = 1'b1;
    apply_stimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_result(0);
    consume();

    // Reset while the third nibble is being processed.
    apply_stimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_output("midrst_in_ready", in_ready, 1);
    check_output("midrst_out_valid", out_valid, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_sum", sum, 0);
    check_output("midrst_cout", cout, 0);
    check_output("midrst_ovf", ovf, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("midrst_no_result", out_valid, 0);
    end
    do_op(16'h0010, 16'h0020, 1'b0, 1'b0, 0);

    // Randomized operations with random hold and back-to-back choice.
    apply_stimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    for (int n = 0; n < 40; n++) begin
      wait_result(int'($urandom_range(0, 3)));
      if (n == 39) begin
        consume();
      end else if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b1;
        apply_stimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        consume();
        apply_stimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
